// File: rtl/ldtu_dec_pkg.sv
// Shared constants and types for the LiTe-DTU back-end decoder.
// Holds the word prefixes, the word-class and FSM state enums, and sample formatting.
package ldtu_dec_pkg;

  localparam logic [1:0]  BASE      = 2'b01;
  localparam logic [3:0]  PBASE     = 4'b1010;
  localparam logic [5:0]  SIG2      = 6'b001010;
  localparam logic [5:0]  SIG1      = 6'b001011;
  localparam logic [3:0]  HDR       = 4'b1101;
  localparam logic [31:0] IDLE_WORD = 32'hEAAA_AAAA;

  localparam int BASE_W = 6;
  localparam int SIG_W  = 13;
  localparam int SH_W   = 30;

  typedef enum logic [2:0] {
    C_BASE,
    C_PBASE,
    C_SIG2,
    C_SIG1,
    C_HDR,
    C_IDLE,
    C_BAD
  } word_class_t;

  typedef enum logic {
    WAIT,
    UNPACK
  } state_t;

  // Baseline samples are 6 bits and zero-extended; signal samples pass through.
  function automatic logic [12:0] fmt_sample(input logic [SH_W-1:0] sh, input logic is_sig);
    return is_sig ? sh[12:0] : {7'b0, sh[5:0]};
  endfunction

endpackage

// File: rtl/ldtu_dec_classify.sv
// Combinational word classifier: maps a packed LiTe-DTU word to its class,
// the number of samples it carries and the width of each sample.
module ldtu_dec_classify
  import ldtu_dec_pkg::*;
(
  input  logic [31:0]  word,
  output word_class_t  cls,
  output logic [2:0]   n_samp,
  output logic [3:0]   samp_w
);

  always_comb begin
    cls    = C_BAD;
    n_samp = 3'd0;
    samp_w = 4'(BASE_W);
    // Idle is a full-word match and is checked first so its 1110 prefix never aliases.
    if (word == IDLE_WORD) begin
      cls = C_IDLE;
    end else if (word[31:30] == BASE) begin
      cls    = C_BASE;
      n_samp = 3'd5;
    end else if (word[31:28] == PBASE) begin
      if (word[27:24] != 4'd0 && word[27:24] <= 4'd4) begin
        cls    = C_PBASE;
        n_samp = word[26:24];
      end
    end else if (word[31:26] == SIG2) begin
      cls    = C_SIG2;
      n_samp = 3'd2;
      samp_w = 4'(SIG_W);
    end else if (word[31:26] == SIG1) begin
      cls    = C_SIG1;
      n_samp = 3'd1;
      samp_w = 4'(SIG_W);
    end else if (word[31:28] == HDR) begin
      cls = C_HDR;
    end
  end

endmodule

// File: rtl/ldtu_decoder.sv
// LiTe-DTU stream decoder: unpacks 32-bit words into one 13-bit sample per clock,
// tracks orbit (BC0) markers, word-lock status and a saturating malformed-word count.
module ldtu_decoder
  import ldtu_dec_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [31:0]      in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [12:0]      sample_data,
  output logic             sample_valid,
  output logic             sample_baseline,
  output logic             orbit_marker,
  output logic             locked,
  output logic [ERR_W-1:0] err_count,
  output state_t           st
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  // Handshake: a word transfers on a rising CLK edge when in_valid and in_ready
  // are both high; in_ready does not depend on in_valid.

  word_class_t       cls;
  logic [2:0]        n_samp;
  logic [3:0]        samp_w;

  state_t            st_q, st_d;
  logic [SH_W-1:0]   sh_q;
  logic [2:0]        rem_q;
  logic              sig_q;
  logic              mark_q;
  logic              pend_q;
  logic [GW-1:0]     good_q;
  logic [ERR_W-1:0]  err_q;

  logic              accept;
  logic              load;

  ldtu_dec_classify u_classify (
    .word   (in_word),
    .cls    (cls),
    .n_samp (n_samp),
    .samp_w (samp_w)
  );

  // rem_q counts samples left in the current word, including the one on the outputs.
  assign in_ready = (st_q == WAIT) || (rem_q == 3'd1);
  assign accept   = in_valid && in_ready;
  assign load     = accept && (n_samp != 3'd0);

  always_ff @(posedge CLK) begin
    if (rst) st_q <= WAIT;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      WAIT:    if (load) st_d = UNPACK;
      UNPACK:  if (rem_q == 3'd1 && !load) st_d = WAIT;
      default: st_d = WAIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      sh_q   <= '0;
      rem_q  <= '0;
      sig_q  <= 1'b0;
      mark_q <= 1'b0;
      pend_q <= 1'b0;
      good_q <= '0;
      err_q  <= '0;
    end else begin
      if (load) begin
        sh_q   <= in_word[SH_W-1:0];
        rem_q  <= n_samp;
        sig_q  <= (samp_w == 4'(SIG_W));
        mark_q <= pend_q;
      end else if (st_q == UNPACK) begin
        sh_q   <= sig_q ? (sh_q >> SIG_W) : (sh_q >> BASE_W);
        rem_q  <= rem_q - 3'd1;
        mark_q <= 1'b0;
      end

      // A header arms the marker; the next sample-bearing word consumes it.
      if (accept && cls == C_HDR) pend_q <= 1'b1;
      else if (load)              pend_q <= 1'b0;

      if (accept) begin
        if (cls == C_BAD) begin
          good_q <= '0;
          if (err_q != '1) err_q <= err_q + ERR_W'(1);
        end else if (good_q != GW'(LOCK_COUNT)) begin
          good_q <= good_q + GW'(1);
        end
      end
    end
  end

  assign st              = st_q;
  assign sample_valid    = (st_q == UNPACK);
  assign sample_data     = sample_valid ? fmt_sample(sh_q, sig_q) : 13'd0;
  assign sample_baseline = sample_valid && !sig_q;
  assign orbit_marker    = sample_valid && mark_q;
  assign locked          = (good_q == GW'(LOCK_COUNT));
  assign err_count       = err_q;

endmodule

// File: tb/tb_ldtu_decoder.sv
// Self-checking bench for ldtu_decoder: a queue-based behavioural model checked every
// cycle, directed words with literal expectations, then randomized mixed traffic.
module tb_ldtu_decoder;
  import ldtu_dec_pkg::*;

  localparam int LOCK_COUNT = 4;
  localparam int ERR_W      = 8;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;

  logic             CLK = 1'b0;
  logic             rst;
  logic [31:0]      in_word;
  logic             in_valid;
  logic             in_ready;
  logic [12:0]      sample_data;
  logic             sample_valid;
  logic             sample_baseline;
  logic             orbit_marker;
  logic             locked;
  logic [ERR_W-1:0] err_count;
  state_t           st;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected samples of the word being emitted: {marker, baseline, data[12:0]}.
  logic [14:0] exp_q[$];
  bit          m_pend = 1'b0;
  int          m_good = 0;
  int          m_err  = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  ldtu_decoder #(.LOCK_COUNT(LOCK_COUNT), .ERR_W(ERR_W)) dut (
    .CLK             (CLK),
    .rst             (rst),
    .in_word         (in_word),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .sample_data     (sample_data),
    .sample_valid    (sample_valid),
    .sample_baseline (sample_baseline),
    .orbit_marker    (orbit_marker),
    .locked          (locked),
    .err_count       (err_count),
    .st              (st)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Advances the model across the coming rising edge using the inputs now applied.
  task automatic model_step();
    bit          rdy;
    int          n;
    int          w;
    bit          ok;
    logic [31:0] x;
    logic [31:0] v;
    logic [12:0] d;
    rdy = (exp_q.size() <= 1);
    n = 0; w = 6; ok = 1'b1; x = in_word;
    if (rst) begin
      exp_q.delete();
      m_pend = 1'b0;
      m_good = 0;
      m_err  = 0;
      return;
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (!(in_valid && rdy)) return;
    if (x == 32'hEAAA_AAAA) ;
    else if (x[31:30] == 2'b01) n = 5;
    else if (x[31:28] == 4'hA) begin
      n = int'(x[27:24]);
      if (n < 1 || n > 4) begin ok = 1'b0; n = 0; end
    end
    else if (x[31:26] == 6'b001010) begin n = 2; w = 13; end
    else if (x[31:26] == 6'b001011) begin n = 1; w = 13; end
    else if (x[31:28] == 4'hD) m_pend = 1'b1;
    else ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      v = (x >> (w * i)) & ((32'd1 << w) - 32'd1);
      d = v[12:0];
      exp_q.push_back({(i == 0) && m_pend, (w == 6), d});
    end
    if (n > 0) m_pend = 1'b0;
    if (ok) m_good = (m_good < LOCK_COUNT) ? m_good + 1 : LOCK_COUNT;
    else begin
      m_good = 0;
      m_err  = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge CLK) begin
    logic [14:0] e;
    check("in_ready", in_ready, exp_q.size() <= 1);
    check("sample_valid", sample_valid, exp_q.size() > 0);
    check("st", 32'(st), (exp_q.size() > 0) ? 32'(UNPACK) : 32'(WAIT));
    check("locked", locked, m_good == LOCK_COUNT);
    check("err_count", err_count, m_err);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check("sample_data", sample_data, e[12:0]);
      check("sample_baseline", sample_baseline, e[13]);
      check("orbit_marker", orbit_marker, e[14]);
    end
    model_step();
  end

  // ---------------- driver ----------------
  // Presents a word until accepted; returns #1 after the edge that transferred it.
  task automatic send(input logic [31:0] w);
    int budget;
    budget = 0;
    in_word  = w;
    in_valid = 1'b1;
    while (!in_ready && budget < 50) begin
      @(posedge CLK); #1;
      budget++;
    end
    if (budget >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: word 0x%0h not accepted within 50 cycles", w);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 7))
      0:       return {2'b01, r[29:0]};
      1:       return {4'hA, 4'($urandom_range(0, 6)), r[23:0]};
      2:       return {6'b001010, r[25:0]};
      3:       return {6'b001011, r[25:0]};
      4:       return {4'hD, r[27:0]};
      5:       return 32'hEAAA_AAAA;
      default: return r;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_word = '0;
    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_sample_data", sample_data, 0);
    check("rst_locked", locked, 0);
    check("rst_err_count", err_count, 0);

    // Baseline word: samples 1,1,0,0,0.
    send(32'h4000_0041);
    check("base_s0", sample_data, 13'h001);
    check("base_bl", sample_baseline, 1);
    check("base_ready_low", in_ready, 0);
    idle_cycles(1);
    check("base_s1", sample_data, 13'h001);
    idle_cycles(5);

    // Back-to-back double-signal words.
    send(32'h2800_2001);
    check("sig2_a0", sample_data, 13'h001);
    send(32'h2BFF_FFFF);
    check("sig2_b0", sample_data, 13'h1FFF);
    check("sig2_b0_bl", sample_baseline, 0);
    idle_cycles(3);

    // Reset during the third baseline sample.
    send(32'h4000_0041);
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    check("rstmid_valid", sample_valid, 0);
    check("rstmid_st", 32'(st), 32'(WAIT));
    idle_cycles(6);

    // Lock, then a malformed word.
    repeat (4) send(32'hEAAA_AAAA);
    check("lock_on", locked, 1);
    send(32'hFFFF_FFFF);
    check("lock_off", locked, 0);
    check("err_one", err_count, 1);
    check("bad_no_sample", sample_valid, 0);

    // Partial baseline N=3, then N=5 (malformed).
    send(32'hA300_0FFF);
    check("pbase_s0", sample_data, 13'h03F);
    idle_cycles(3);
    send(32'hA500_0FFF);
    check("pbase_bad_err", err_count, 2);
    check("pbase_bad_nosample", sample_valid, 0);

    // Header, idle, baseline: marker only on its first sample.
    send(32'hD000_0000);
    send(32'hEAAA_AAAA);
    send(32'h4000_003F);
    check("orbit_on", orbit_marker, 1);
    check("orbit_data", sample_data, 13'h03F);
    idle_cycles(1);
    check("orbit_once", orbit_marker, 0);
    idle_cycles(5);

    // Header taken alongside the last sample of a word marks the next word.
    send(32'h2800_2001);
    check("hdr_late_cur", orbit_marker, 0);
    send(32'hD000_0000);
    check("hdr_late_last", orbit_marker, 0);
    send(32'h4000_0041);
    check("hdr_late_next", orbit_marker, 1);
    idle_cycles(6);

    // Error counter saturation.
    repeat (300) send(32'hFFFF_FFFF);
    check("err_sat", err_count, ERR_MAX);

    // Randomized mixed traffic with occasional resets.
    repeat (2000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_word  = rand_word();
      rst      = ($urandom_range(0, 199) == 0);
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    rst = 1'b0;
    idle_cycles(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
